// File: rtl/sdram_wr_sequencer.sv
// Write-path sequencer: parses a 3-word header from the USB FIFO and streams payload beats to the SDRAM write channel.
// Optional bounds checking (no address wrap, sticky addr_err) is enabled by defining SDRAM_WR_BOUNDS_CHK_EN.
module sdram_wr_sequencer #(
  parameter logic [31:0] ADDR_LIMIT = 32'h00FF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sdram_init_done,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] wr_data,
  output logic [31:0] wr_addr,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        addr_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_HI, S_HDR_LO, S_HDR_LEN, S_DATA, S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] remain_q, remain_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic        wr_valid_q, wr_valid_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] addr_inc;
  logic        issue;
  logic        accept;

`ifdef SDRAM_WR_BOUNDS_CHK_EN
  logic addr_err_q, addr_err_d;
  assign addr_inc = addr_q + 32'd1;
  assign issue    = (addr_q <= ADDR_LIMIT);
  assign addr_err = addr_err_q;
`else
  assign addr_inc = (addr_q == ADDR_LIMIT) ? 32'd0 : addr_q + 32'd1;
  assign issue    = 1'b1;
  assign addr_err = 1'b0;
`endif

  // Headers always flow; payload is held off once the last word is in or the output beat is stalled.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_HDR_HI, S_HDR_LO, S_HDR_LEN: in_ready = 1'b1;
      S_DATA:  in_ready = (remain_q != 16'd0) && (!wr_valid_q || wr_ready);
      default: in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remain_d     = remain_q;
    wr_data_d    = wr_data_q;
    wr_addr_d    = wr_addr_q;
    wr_valid_d   = wr_valid_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
`ifdef SDRAM_WR_BOUNDS_CHK_EN
    addr_err_d   = addr_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (sdram_init_done) state_d = S_HDR_HI;
      end
      S_HDR_HI: begin
        if (accept) begin
          addr_d[31:16] = in_data;
          busy_d        = 1'b1;
          state_d       = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (accept) begin
          addr_d[15:0] = in_data;
          state_d      = S_HDR_LEN;
        end
      end
      S_HDR_LEN: begin
        if (accept) begin
          remain_d = in_data;
`ifdef SDRAM_WR_BOUNDS_CHK_EN
          addr_err_d = 1'b0;
`endif
          if (in_data == 16'd0) begin
            state_d      = S_DONE;
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 16'd1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (wr_ready) wr_valid_d = 1'b0;
        if (accept) begin
          addr_d   = addr_inc;
          remain_d = remain_q - 16'd1;
          if (issue) begin
            wr_data_d  = in_data;
            wr_addr_d  = addr_q;
            wr_valid_d = 1'b1;
          end
`ifdef SDRAM_WR_BOUNDS_CHK_EN
          else addr_err_d = 1'b1;
`endif
        end
        // Frame ends once every word is in and the final beat has retired.
        if ((remain_q == 16'd0) && (!wr_valid_q || wr_ready)) begin
          state_d      = S_DONE;
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = sdram_init_done ? S_HDR_HI : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= 32'd0;
      remain_q     <= 16'd0;
      wr_data_q    <= 16'd0;
      wr_addr_q    <= 32'd0;
      wr_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 16'd0;
`ifdef SDRAM_WR_BOUNDS_CHK_EN
      addr_err_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remain_q     <= remain_d;
      wr_data_q    <= wr_data_d;
      wr_addr_q    <= wr_addr_d;
      wr_valid_q   <= wr_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
`ifdef SDRAM_WR_BOUNDS_CHK_EN
      addr_err_q   <= addr_err_d;
`endif
    end
  end

  assign wr_data    = wr_data_q;
  assign wr_addr    = wr_addr_q;
  assign wr_valid   = wr_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
